// File: rtl/mul_seq_unit_if.sv
// Handshake bundle for the sequential shift-add multiplier.
// Requester drives operands/start/abort; the unit returns status and product.
interface mul_seq_unit_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic               abort;
    logic               signed_mode;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, abort, signed_mode, a_in, b_in,
        input  busy, done, product
    );

    modport slave (
        input  start, abort, signed_mode, a_in, b_in,
        output busy, done, product
    );
endinterface

// File: rtl/mul_seq_unit.sv
// Sequential shift-add multiplier, unsigned or two's-complement operands.
// Iterates on operand magnitudes and stops after the last set multiplier bit.
module mul_seq_unit #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    mul_seq_unit_if.slave m
);
    typedef enum logic {IDLE, CALC} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // -2^(WIDTH-1) negates to itself, which read unsigned is the right magnitude
    assign a_mag = (m.signed_mode && m.a_in[WIDTH-1]) ? -m.a_in : m.a_in;
    assign b_mag = (m.signed_mode && m.b_in[WIDTH-1]) ? -m.b_in : m.b_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m.start && !m.abort) begin
                    a_sh_d  = {{WIDTH{1'b0}}, a_mag};
                    b_sh_d  = b_mag;
                    acc_d   = '0;
                    neg_d   = m.signed_mode
                            & (m.a_in[WIDTH-1] ^ m.b_in[WIDTH-1]);
                    state_d = CALC;
                end
            end
            CALC: begin
                // abort outranks a completion in the same cycle
                if (m.abort) begin
                    state_d = IDLE;
                end else if (b_sh_q != '0) begin
                    if (b_sh_q[0]) begin
                        acc_d = acc_q + a_sh_q;
                    end
                    a_sh_d = a_sh_q << 1;
                    b_sh_d = b_sh_q >> 1;
                end else begin
                    prod_d  = neg_q ? -acc_q : acc_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign m.busy    = (state_q == CALC);
    assign m.done    = done_q;
    assign m.product = prod_q;
endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed bench for mul_seq_unit: vector table plus abort/reset/busy sequences.
module tb_mul_seq_unit;
    localparam int W = 8;

    logic clk;
    logic rst_n;

    mul_seq_unit_if #(.WIDTH(W)) bus ();

    mul_seq_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           sm;
        logic [2*W-1:0] prod;
        int             lat;
    } vec_t;

    int n_pass;
    int n_total;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Called away from a clock edge; returns #1 after an edge.
    task automatic do_op(input string name, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sm,
                         input logic [2*W-1:0] prod, input int lat);
        int seen;
        int busy_n;
        seen   = 0;
        busy_n = 0;
        bus.start       = 1'b1;
        bus.a_in        = a;
        bus.b_in        = b;
        bus.signed_mode = sm;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a_in  = ~a;
        bus.b_in  = ~b;
        if (bus.busy) busy_n++;
        for (int n = 1; n <= W + 4; n++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_n++;
            if (bus.done) begin
                seen = n;
                break;
            end
        end
        check({name, " latency"}, seen, lat);
        check({name, " busy cycles"}, busy_n, lat);
        check({name, " product"}, {16'd0, bus.product}, {16'd0, prod});
        @(posedge clk);
        #1;
        check({name, " done pulse width"}, {31'd0, bus.done}, 32'd0);
    endtask

    vec_t vecs[10];
    int   dn;

    initial begin
        n_pass  = 0;
        n_total = 0;
        vecs[0] = '{8'd13,  8'd11,  1'b0, 16'h008F, 5};
        vecs[1] = '{8'hFD,  8'h05,  1'b1, 16'hFFF1, 4};
        vecs[2] = '{8'h80,  8'h80,  1'b1, 16'h4000, 9};
        vecs[3] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01, 9};
        vecs[4] = '{8'hAB,  8'h00,  1'b0, 16'h0000, 1};
        vecs[5] = '{8'h7F,  8'hFF,  1'b1, 16'hFF81, 2};
        vecs[6] = '{8'hFF,  8'h02,  1'b1, 16'hFFFE, 3};
        vecs[7] = '{8'h80,  8'h01,  1'b0, 16'h0080, 2};
        vecs[8] = '{8'h80,  8'h7F,  1'b1, 16'hC080, 8};
        vecs[9] = '{8'd6,   8'd7,   1'b0, 16'h002A, 4};

        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.a_in        = '0;
        bus.b_in        = '0;
        #1;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset product", {16'd0, bus.product}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                  vecs[i].sm, vecs[i].prod, vecs[i].lat);
        end

        // start ignored while busy: only 200 x 3 completes
        bus.start = 1'b1; bus.a_in = 8'd200; bus.b_in = 8'd3;
        bus.signed_mode = 1'b0;
        @(posedge clk);
        dn = 0;
        for (int i = 1; i <= 14; i++) begin
            #1;
            if (bus.done) dn++;
            bus.start = (i <= 2);
            bus.a_in  = 8'd7;
            bus.b_in  = 8'd7;
            @(posedge clk);
        end
        #1;
        check("busy start done count", dn, 1);
        check("busy start product", {16'd0, bus.product}, 32'h0258);

        // abort in IDLE blocks a coincident start
        bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        check("idle abort blocks start", {31'd0, bus.busy}, 32'd0);

        // abort mid-operation
        do_op("pre-abort", 8'd6, 8'd7, 1'b0, 16'h002A, 4);
        bus.start = 1'b1; bus.a_in = 8'hFF; bus.b_in = 8'hFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("abort busy drop", {31'd0, bus.busy}, 32'd0);
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) dn++;
            @(posedge clk);
            #1;
        end
        check("abort no done", dn, 0);
        check("abort product held", {16'd0, bus.product}, 32'h002A);

        // abort coinciding with completion (b = 0)
        bus.start = 1'b1; bus.a_in = 8'hAB; bus.b_in = 8'h00;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("abort vs finish done", {31'd0, bus.done}, 32'd0);
        check("abort vs finish busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        check("abort vs finish product", {16'd0, bus.product}, 32'h002A);

        // asynchronous reset mid-operation
        bus.start = 1'b1; bus.a_in = 8'hFF; bus.b_in = 8'hFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset busy", {31'd0, bus.busy}, 32'd0);
        check("mid reset done", {31'd0, bus.done}, 32'd0);
        check("mid reset product", {16'd0, bus.product}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dn++;
        end
        check("post reset no done", dn, 0);
        do_op("post reset 2x3", 8'd2, 8'd3, 1'b0, 16'h0006, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
